// File: rtl/lb_sweep_pkg.sv
`default_nettype none
// ============================================================================
// lb_sweep_pkg : shared widths, sweep FSM states and constants for the scorer
// Revision     : 1.0  initial release
// ============================================================================
package lb_sweep_pkg;

   localparam int RES_W_DEF = 17;
   localparam int KEY_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sweep_state_e;

   // Truncated to the counter width by users; all-ones marks "no failure seen".
   localparam logic [63:0] FIRST_FAIL_NONE = '1;

endpackage
`default_nettype wire

// File: rtl/locked_response_scorer_if.sv
`default_nettype none
// ============================================================================
// locked_response_scorer_if : sample stream carrying locked and golden responses
// Revision                  : 1.0  initial release
// ============================================================================
interface locked_response_scorer_if #(
   parameter int RES_W = lb_sweep_pkg::RES_W_DEF
);
   logic             s_valid;
   logic             s_ready;
   logic [RES_W-1:0] result;
   logic [RES_W-1:0] golden;

   modport master (output s_valid, output result, output golden, input s_ready);
   modport slave  (input s_valid, input result, input golden, output s_ready);
endinterface
`default_nettype wire

// File: rtl/popcount_reg.sv
`default_nettype none
// ============================================================================
// popcount_reg : registered population count and nonzero flag of a W-bit word
// Revision     : 1.0  initial release
// ============================================================================
module popcount_reg #(
   parameter int W  = 17,
   parameter int CW = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  data_i,
   output logic [CW-1:0] cnt_o,
   output logic          nz_o
);
   logic [CW-1:0] cnt_d;
   logic [CW-1:0] cnt_q;
   logic          nz_q;

   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < W; i++) begin
         cnt_d = cnt_d + CW'(data_i[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         nz_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         nz_q  <= |data_i;
      end
   end

   assign cnt_o = cnt_q;
   assign nz_o  = nz_q;
endmodule
`default_nettype wire

// File: rtl/locked_response_scorer.sv
`default_nettype none
// ============================================================================
// locked_response_scorer : per-key-sweep mismatch, bit-flip and first-fail stats
// Revision               : 1.0  initial release
// ============================================================================
module locked_response_scorer
   import lb_sweep_pkg::*;
#(
   parameter int RES_W     = RES_W_DEF,
   parameter int KEY_W     = KEY_W_DEF,
   parameter int N_VECTORS = 10000,
   parameter int CNT_W     = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start_i,
   input  logic [KEY_W-1:0]           key_i,
   locked_response_scorer_if.slave    smp,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [KEY_W-1:0]           key_o,
   output logic [CNT_W-1:0]           mismatch_cnt_o,
   output logic [CNT_W-1:0]           bitflip_cnt_o,
   output logic [CNT_W-1:0]           first_fail_idx_o,
   output logic                       first_fail_vld_o
);
   localparam int               IDX_W    = (N_VECTORS > 1) ? $clog2(N_VECTORS) : 1;
   localparam int               PC_W     = $clog2(RES_W + 1);
   localparam int               SUM_W    = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VECTORS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   sweep_state_e     state_q, state_d;
   logic             w_ready;
   logic             w_accept;
   logic             w_start;
   logic [IDX_W-1:0] idx_q;

   logic             s1_vld_q;
   logic [RES_W-1:0] s1_xor_q;
   logic [IDX_W-1:0] s1_idx_q;
   logic             s2_vld_q;
   logic [IDX_W-1:0] s2_idx_q;
   logic [PC_W-1:0]  s2_pc;
   logic             s2_nz;

   logic [KEY_W-1:0] key_q;
   logic [CNT_W-1:0] mis_q, bf_q, ffi_q;
   logic             ffv_q;
   logic [SUM_W-1:0] w_sum;
   logic [CNT_W-1:0] w_bf_sat;

   assign w_start  = start_i && (state_q == IDLE);
   assign w_accept = smp.s_valid && w_ready;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // S2 retires on the same edge that leaves DRAIN, so only S1 gates the exit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = RUN;
         RUN:     if (w_accept && (idx_q == LAST_IDX)) state_d = DRAIN;
         DRAIN:   if (!s1_vld_q) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      w_ready = 1'b0;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         RUN:     begin w_ready = 1'b1; busy_o = 1'b1; end
         DRAIN:   busy_o = 1'b1;
         DONE:    done_o = 1'b1;
         default: ;
      endcase
   end

   assign smp.s_ready = w_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q    <= '0;
         s1_vld_q <= 1'b0;
         s1_xor_q <= '0;
         s1_idx_q <= '0;
         s2_vld_q <= 1'b0;
         s2_idx_q <= '0;
      end else begin
         if (w_start)       idx_q <= '0;
         else if (w_accept) idx_q <= idx_q + IDX_W'(1);
         s1_vld_q <= w_accept;
         s1_xor_q <= smp.result ^ smp.golden;
         s1_idx_q <= idx_q;
         s2_vld_q <= s1_vld_q;
         s2_idx_q <= s1_idx_q;
      end
   end

   popcount_reg #(
      .W  (RES_W),
      .CW (PC_W)
   ) u_popcount (
      .clk    (clk),
      .rst    (rst),
      .data_i (s1_xor_q),
      .cnt_o  (s2_pc),
      .nz_o   (s2_nz)
   );

   assign w_sum    = SUM_W'(bf_q) + SUM_W'(s2_pc);
   assign w_bf_sat = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         key_q <= '0;
         mis_q <= '0;
         bf_q  <= '0;
         ffi_q <= CNT_W'(FIRST_FAIL_NONE);
         ffv_q <= 1'b0;
      end else if (w_start) begin
         key_q <= key_i;
         mis_q <= '0;
         bf_q  <= '0;
         ffi_q <= CNT_W'(FIRST_FAIL_NONE);
         ffv_q <= 1'b0;
      end else if (s2_vld_q) begin
         bf_q <= w_bf_sat;
         if (s2_nz) begin
            if (mis_q != CNT_MAX) mis_q <= mis_q + CNT_W'(1);
            if (!ffv_q) begin
               ffi_q <= CNT_W'(s2_idx_q);
               ffv_q <= 1'b1;
            end
         end
      end
   end

   assign key_o            = key_q;
   assign mismatch_cnt_o   = mis_q;
   assign bitflip_cnt_o    = bf_q;
   assign first_fail_idx_o = ffi_q;
   assign first_fail_vld_o = ffv_q;
endmodule
`default_nettype wire

// File: tb/tb_locked_response_scorer.sv
`default_nettype none
// ============================================================================
// tb_locked_response_scorer : scoreboard bench for three scorer configurations
// Revision                  : 1.0  initial release
// ============================================================================
module tb_locked_response_scorer;
   typedef struct {
      logic [31:0] key;
      logic [31:0] mis;
      logic [31:0] bf;
      logic [31:0] ffi;
      logic        ffv;
      int          nacc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  start;
   logic [31:0] key_in;
   logic        s_valid;
   logic [16:0] result, golden;

   logic [2:0]  busy, done, ready, ffv;
   logic [31:0] keyo [3];
   logic [31:0] mis  [3];
   logic [31:0] bf   [3];
   logic [31:0] ffi  [3];
   logic [3:0]  mis_b, bf_b, ffi_b;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   acc_cnt [3];
   int   last_acc [3];
   exp_t qa[$], qb[$], qc[$];

   always #5 clk = ~clk;

   locked_response_scorer_if #(.RES_W(17)) if_a ();
   locked_response_scorer_if #(.RES_W(17)) if_b ();
   locked_response_scorer_if #(.RES_W(17)) if_c ();

   assign if_a.s_valid = s_valid;  assign if_a.result = result;  assign if_a.golden = golden;
   assign if_b.s_valid = s_valid;  assign if_b.result = result;  assign if_b.golden = golden;
   assign if_c.s_valid = s_valid;  assign if_c.result = result;  assign if_c.golden = golden;
   assign ready = {if_c.s_ready, if_b.s_ready, if_a.s_ready};

   locked_response_scorer #(.RES_W(17), .KEY_W(32), .N_VECTORS(8), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .start_i(start[0]), .key_i(key_in), .smp(if_a),
      .busy_o(busy[0]), .done_o(done[0]), .key_o(keyo[0]), .mismatch_cnt_o(mis[0]),
      .bitflip_cnt_o(bf[0]), .first_fail_idx_o(ffi[0]), .first_fail_vld_o(ffv[0]));

   locked_response_scorer #(.RES_W(17), .KEY_W(32), .N_VECTORS(8), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .start_i(start[1]), .key_i(key_in), .smp(if_b),
      .busy_o(busy[1]), .done_o(done[1]), .key_o(keyo[1]), .mismatch_cnt_o(mis_b),
      .bitflip_cnt_o(bf_b), .first_fail_idx_o(ffi_b), .first_fail_vld_o(ffv[1]));

   assign mis[1] = {28'd0, mis_b};
   assign bf[1]  = {28'd0, bf_b};
   assign ffi[1] = {28'd0, ffi_b};

   locked_response_scorer #(.RES_W(17), .KEY_W(32), .N_VECTORS(1), .CNT_W(32)) dut_c (
      .clk(clk), .rst(rst), .start_i(start[2]), .key_i(key_in), .smp(if_c),
      .busy_o(busy[2]), .done_o(done[2]), .key_o(keyo[2]), .mismatch_cnt_o(mis[2]),
      .bitflip_cnt_o(bf[2]), .first_fail_idx_o(ffi[2]), .first_fail_vld_o(ffv[2]));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] k, input logic [31:0] m, input logic [31:0] b,
                               input logic [31:0] f, input logic v, input int n);
      exp_t e;
      e.key = k; e.mis = m; e.bf = b; e.ffi = f; e.ffv = v; e.nacc = n;
      return e;
   endfunction

   task automatic score(input int d);
      exp_t e;
      bit   have;
      have = 1'b0;
      case (d)
         0: if (qa.size() != 0) begin e = qa.pop_front(); have = 1'b1; end
         1: if (qb.size() != 0) begin e = qb.pop_front(); have = 1'b1; end
         default: if (qc.size() != 0) begin e = qc.pop_front(); have = 1'b1; end
      endcase
      chk($sformatf("d%0d_done_expected", d), 64'(have), 64'd1);
      if (have) begin
         chk($sformatf("d%0d_key", d),      keyo[d], e.key);
         chk($sformatf("d%0d_mismatch", d), mis[d],  e.mis);
         chk($sformatf("d%0d_bitflip", d),  bf[d],   e.bf);
         chk($sformatf("d%0d_ff_idx", d),   ffi[d],  e.ffi);
         chk($sformatf("d%0d_ff_vld", d),   ffv[d],  e.ffv);
         chk($sformatf("d%0d_accepts", d),  acc_cnt[d], e.nacc);
         chk($sformatf("d%0d_done_lat", d), cyc - last_acc[d], 3);
      end
      acc_cnt[d] = 0;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: counts handshakes and pops the scoreboard on every done pulse.
   initial begin
      for (int d = 0; d < 3; d++) begin acc_cnt[d] = 0; last_acc[d] = 0; end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            if (rst) acc_cnt[d] = 0;
            else begin
               if (s_valid && ready[d]) begin acc_cnt[d]++; last_acc[d] = cyc; end
               if (done[d]) score(d);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send(input logic [16:0] g, input logic [16:0] x);
      s_valid = 1'b1; golden = g; result = g ^ x;
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic start_sweep(input int d, input logic [31:0] k);
      start[d] = 1'b1; key_in = k;
      @(posedge clk); #1;
      start[d] = 1'b0;
   endtask

   task automatic wait_done(input int d);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (done[d]) seen = 1'b1;
      end
      if (!seen) begin
         checks++; failures++;
         $display("FAIL d%0d_done_timeout: got no done expected done within 40 cycles", d);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end expected end before 100us");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = '0; key_in = '0; s_valid = 1'b0; result = '0; golden = '0;
      idle(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy[0], 0);   chk("rst_done", done[0], 0);
      chk("rst_ready", ready[0], 0); chk("rst_mis", mis[0], 0);
      chk("rst_bf", bf[0], 0);       chk("rst_ffi", ffi[0], 32'hFFFF_FFFF);
      chk("rst_ffv", ffv[0], 0);     chk("rst_key", keyo[0], 0);
      chk("rst_ffi_b", ffi[1], 32'h0000_000F);
      @(posedge clk); #1;

      // Correct key: no mismatches at all
      start_sweep(0, 32'h00B8_9EB1);
      qa.push_back(mk(32'h00B8_9EB1, 0, 0, 32'hFFFF_FFFF, 1'b0, 8));
      for (int i = 0; i < 8; i++) send(17'(i * 4099 + 7), 17'h0);
      wait_done(0);

      // Wrong key: flips at indices 2 (two bits) and 5 (carry bit)
      start_sweep(0, 32'h00B8_9EB0);
      qa.push_back(mk(32'h00B8_9EB0, 2, 3, 2, 1'b1, 8));
      for (int i = 0; i < 8; i++)
         send(17'(i * 997 + 3), (i == 2) ? 17'h00003 : (i == 5) ? 17'h10000 : 17'h0);
      wait_done(0);

      // Gapped valid, every bit flipped; later samples in DRAIN/DONE/IDLE ignored
      start_sweep(0, 32'h0000_A5A5);
      qa.push_back(mk(32'h0000_A5A5, 8, 136, 0, 1'b1, 8));
      for (int i = 0; i < 8; i++) begin
         send(17'(i * 313), 17'h1FFFF);
         if (i < 7) idle(2);
      end
      s_valid = 1'b1; golden = 17'h00155; result = 17'h00155 ^ 17'h1FFFF;
      wait_done(0);
      idle(4);
      s_valid = 1'b0;
      @(negedge clk);
      chk("hold_mis", mis[0], 8); chk("hold_bf", bf[0], 136); chk("hold_busy", busy[0], 0);
      @(posedge clk); #1;

      // Saturating 4-bit counters
      start_sweep(1, 32'h5A5A_0004);
      qb.push_back(mk(32'h5A5A_0004, 8, 15, 0, 1'b1, 8));
      for (int i = 0; i < 8; i++) send(17'(i * 51 + 1), 17'h1FFFF);
      wait_done(1);

      // Single-vector sweep
      start_sweep(2, 32'h0000_0001);
      qc.push_back(mk(32'h0000_0001, 1, 1, 0, 1'b1, 1));
      idle(1);
      send(17'h0ABCD, 17'h00001);
      wait_done(2);

      // Reset mid-sweep aborts without a done pulse
      start_sweep(0, 32'h1111_2222);
      for (int i = 0; i < 3; i++) send(17'(i + 100), 17'h00001);
      idle(3);
      @(negedge clk);
      chk("mid_mis", mis[0], 3); chk("mid_bf", bf[0], 3); chk("mid_busy", busy[0], 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy[0], 0); chk("abort_mis", mis[0], 0);
      chk("abort_bf", bf[0], 0);     chk("abort_ffi", ffi[0], 32'hFFFF_FFFF);
      chk("abort_ffv", ffv[0], 0);   chk("abort_key", keyo[0], 0);
      @(posedge clk); #1;
      idle(6);
      start_sweep(0, 32'h1234_5678);
      qa.push_back(mk(32'h1234_5678, 2, 3, 2, 1'b1, 8));
      for (int i = 0; i < 8; i++)
         send(17'(i * 997 + 3), (i == 2) ? 17'h00003 : (i == 5) ? 17'h10000 : 17'h0);
      wait_done(0);

      // start_i during RUN must not relatch the key or restart the count
      start_sweep(0, 32'hCAFE_F00D);
      qa.push_back(mk(32'hCAFE_F00D, 1, 1, 4, 1'b1, 8));
      for (int i = 0; i < 2; i++) send(17'(i + 9), 17'h0);
      start_sweep(0, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("ignored_start_key", keyo[0], 32'hCAFE_F00D);
      @(posedge clk); #1;
      for (int i = 2; i < 8; i++) send(17'(i + 9), (i == 4) ? 17'h00100 : 17'h0);
      wait_done(0);

      idle(5);
      chk("qa_drained", qa.size(), 0);
      chk("qb_drained", qb.size(), 0);
      chk("qc_drained", qc.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/locked_response_scorer.md
Name: locked_response_scorer

Overview:
- Receiving end of the locked-netlist key-sweep flow. A stimulus source drives operand pairs into a key-locked adder and into an unlocked golden instance; this block consumes the resulting response stream.
- For each sample it compares the locked response against the golden response.
- Per key sweep it accumulates the mismatching-vector count, the total output bit-flip count (Hamming distance) and the index of the first failing vector.
- Results go to the sweep controller / log path, so the team gets output-corruption statistics per tested key without running simulation-time monitors.

Parameters:
- RES_W, 17, width of adder response (16-bit operands plus carry).
- KEY_W, 32, key width carried as sweep tag.
- N_VECTORS, 10000, operand pairs per sweep.
- CNT_W, 32, width of the statistics counters (saturating).

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- start_i, input, 1, single-cycle pulse; begins a sweep; accepted only in IDLE.
- key_i, input, KEY_W, key under test; latched on accepted start_i.
- s_valid_i, input, 1, sample valid.
- s_ready_o, output, 1, block can accept a sample.
- result_i, input, RES_W, locked-adder response.
- golden_i, input, RES_W, correct-key (golden) response.
- busy_o, output, 1, sweep in progress.
- done_o, output, 1, one-cycle pulse when sweep statistics are final.
- key_o, output, KEY_W, latched key of the current/last sweep.
- mismatch_cnt_o, output, CNT_W, number of vectors with result_i != golden_i.
- bitflip_cnt_o, output, CNT_W, sum of popcount(result_i ^ golden_i).
- first_fail_idx_o, output, CNT_W, index of first mismatching vector; all-ones if none.
- first_fail_vld_o, output, 1, a mismatch was seen this sweep.

Behaviour:
- Reset values:
  - All count and index outputs are 0, except first_fail_idx_o, which is all-ones.
  - busy_o=0, done_o=0, s_ready_o=0, first_fail_vld_o=0, key_o=0.
- FSM:
  - IDLE:
    - s_ready_o=0.
    - start_i -> RUN: clears all stats, latches key_i, sample index = 0.
  - RUN:
    - s_ready_o=1.
    - A sample is accepted when s_valid_i && s_ready_o.
    - On acceptance of sample N_VECTORS-1 -> DRAIN; s_ready_o drops in the same cycle.
  - DRAIN: waits until the pipeline is empty (2 cycles), then -> DONE.
  - DONE: done_o=1 for exactly one cycle; next state IDLE.
- Outputs hold their values until the next accepted start_i.
- busy_o=1 in RUN and DRAIN.
- Pipeline, fixed 3 stages, no stall needed:
  - S1 registers result_i ^ golden_i plus the sample index.
  - S2 registers the popcount (0..RES_W) and a nonzero flag.
  - S3 updates the accumulators.
  - A sample accepted at cycle t is reflected in the counters at t+3.
  - done_o asserts the cycle after the last sample's update.
- Arithmetic:
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - The popcount is zero-extended before the add.
- First fail:
  - Captured on the first S3 nonzero flag only.
  - Later mismatches leave first_fail_idx_o unchanged.
- Boundary conditions:
  - start_i in RUN/DRAIN/DONE is ignored.
  - s_valid_i outside RUN is dropped (not counted).
  - s_valid_i gaps in RUN are allowed; the index advances only on acceptance.
  - rst mid-sweep aborts to IDLE with reset values; no done_o.
  - N_VECTORS=1 must work: RUN lasts one accepted sample.

Decomposition:
- Shared package lb_sweep_pkg:
  - RES_W/KEY_W defaults.
  - FSM state enum {IDLE, RUN, DRAIN, DONE}.
  - FIRST_FAIL_NONE constant (all-ones).
- One sub-module: popcount_reg (registered popcount of RES_W bits, output width $clog2(RES_W+1)).

Test Plan:
1. Correct key: N_VECTORS=8, golden_i==result_i for all samples -> done_o pulse 3 cycles after the last accept; mismatch_cnt_o=0; bitflip_cnt_o=0; first_fail_vld_o=0; first_fail_idx_o=FFFFFFFF; key_o=00B89EB1.
2. Wrong key (Hamming distance 1): key 00B89EB0, mismatches at indices 2 and 5 with XOR 0x00003 and 0x10000 -> mismatch_cnt_o=2; bitflip_cnt_o=3; first_fail_idx_o=2.
3. Backpressure/gaps: s_valid_i toggled 1,0,0,1… over 8 samples, all with XOR=0x1FFFF -> bitflip_cnt_o=136; mismatch_cnt_o=8; samples presented while in DONE/IDLE are not counted.
4. Saturation: CNT_W=4, 8 samples each with XOR=0x1FFFF -> bitflip_cnt_o=15; mismatch_cnt_o=8.
5. Reset mid-sweep: rst after 3 accepts -> next cycle busy_o=0, counters 0; no done_o; a fresh start_i gives a correct full sweep.
6. Ignored start: start_i pulsed in RUN with a different key_i -> key_o unchanged; sweep completes after exactly N_VECTORS accepts.
